// File: rtl/check_snapshot_pkg.sv
// Shared definitions for the check-data snapshot engine: bus widths and FSM state encoding.
package check_snapshot_pkg;

  localparam int CHECK_ADDR_W = 5;
  localparam int CHECK_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

endpackage

// File: rtl/check_snapshot_if.sv
// Check-data mux bus plus the snapshot output stream; master is the snapshot engine.
interface check_snapshot_if;
  import check_snapshot_pkg::*;

  logic [CHECK_ADDR_W-1:0] check_addr;
  logic [CHECK_DATA_W-1:0] check_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CHECK_ADDR_W-1:0] out_addr;
  logic [CHECK_DATA_W-1:0] out_data;

  modport master (
    output check_addr,
    input  check_data,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data
  );

  modport slave (
    input  check_addr,
    output check_data,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data
  );

endinterface

// File: rtl/check_snapshot_buf.sv
// Snapshot storage: NUM_ADDR words, one write port, one asynchronous read port, async clear.
module check_snapshot_buf
  import check_snapshot_pkg::*;
#(
  parameter int NUM_ADDR = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [CHECK_ADDR_W-1:0] waddr_i,
  input  logic [CHECK_DATA_W-1:0] wdata_i,
  input  logic [CHECK_ADDR_W-1:0] raddr_i,
  output logic [CHECK_DATA_W-1:0] rdata_o
);

  // Index only as many address bits as the array needs so NUM_ADDR=1 still elaborates cleanly.
  localparam int IW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

  logic [CHECK_DATA_W-1:0] mem_q [NUM_ADDR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ADDR; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i[IW-1:0]];

endmodule

// File: rtl/check_snapshot.sv
// Freezes the CPU, captures NUM_ADDR debug check words, then streams them out with valid/ready.
// Optional build macro CHECK_SNAPSHOT_SKIP_ZERO_EN suppresses zero-valued entries during SEND.
module check_snapshot
  import check_snapshot_pkg::*;
#(
  parameter int NUM_ADDR = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  check_snapshot_if.master bus,
  output logic cpu_hold_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CHECK_ADDR_W-1:0] LAST_IDX = CHECK_ADDR_W'(NUM_ADDR - 1);

  state_e                  state_q, state_d;
  logic [CHECK_ADDR_W-1:0] idx_q, idx_d;
  logic                    done_q, done_d;
  logic                    bufWe;
  logic                    sendAdvance;
  logic [CHECK_DATA_W-1:0] bufRdata;

  check_snapshot_buf #(.NUM_ADDR(NUM_ADDR)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bufWe),
    .waddr_i (idx_q),
    .wdata_i (bus.check_data),
    .raddr_i (idx_q),
    .rdata_o (bufRdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    done_d         = 1'b0;
    bufWe          = 1'b0;
    sendAdvance    = 1'b0;
    cpu_hold_o     = 1'b0;
    bus.check_addr = '0;
    bus.out_valid  = 1'b0;
    bus.out_addr   = '0;
    bus.out_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (trig_i) begin
          state_d = ST_CAPTURE;
          idx_d   = '0;
        end
      end
      ST_CAPTURE: begin
        cpu_hold_o     = 1'b1;
        bus.check_addr = idx_q;
        bufWe          = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SEND: begin
        bus.out_addr = idx_q;
        bus.out_data = bufRdata;
`ifdef CHECK_SNAPSHOT_SKIP_ZERO_EN
        // Zero entries are stepped over without waiting for the consumer.
        bus.out_valid = (bufRdata != '0);
        sendAdvance   = (bufRdata == '0) || bus.out_ready;
`else
        bus.out_valid = 1'b1;
        sendAdvance   = bus.out_ready;
`endif
        if (sendAdvance) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_check_snapshot.sv
// Self-checking bench for check_snapshot: randomized mux contents against a word-list model.
module tb_check_snapshot;
  import check_snapshot_pkg::*;

  localparam int NUM_ADDR = 25;

  logic clk;
  logic rst;
  logic trig;
  logic trig1;
  logic cpuHold, busy, done;
  logic cpuHold1, busy1, done1;

  logic [31:0] muxTable [32];
  logic [4:0]  expAddr [$];
  logic [31:0] expData [$];

  int testsRun;
  int failCount;

  check_snapshot_if ifc ();
  check_snapshot_if ifc1 ();

  assign ifc.check_data  = muxTable[ifc.check_addr];
  assign ifc1.check_data = 32'hDEADBEEF;
  assign ifc1.out_ready  = 1'b1;

  check_snapshot #(.NUM_ADDR(NUM_ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_i     (trig),
    .bus        (ifc.master),
    .cpu_hold_o (cpuHold),
    .busy_o     (busy),
    .done_o     (done)
  );

  check_snapshot #(.NUM_ADDR(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .trig_i     (trig1),
    .bus        (ifc1.master),
    .cpu_hold_o (cpuHold1),
    .busy_o     (busy1),
    .done_o     (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic randomizeTable();
    for (int i = 0; i < 32; i++) begin
      muxTable[i] = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
    end
  endtask

  // Expected stream is simply the list of mux values present when the capture starts.
  task automatic buildExpected();
    expAddr.delete();
    expData.delete();
    for (int a = 0; a < NUM_ADDR; a++) begin
`ifdef CHECK_SNAPSHOT_SKIP_ZERO_EN
      if (muxTable[a] == 32'h0) continue;
`endif
      expAddr.push_back(5'(a));
      expData.push_back(muxTable[a]);
    end
  endtask

  // readyMode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic applyStimulus(input int readyMode, input bit spamTrig, input bit trigAtDone, input bit preTriggered);
    int  holdCount;
    int  sendCycles;
    int  stallCycles;
    int  guard;
    bit  doneSeen;
    logic rdy;
    if (!preTriggered) begin
      trig = 1'b1;
      step();
    end
    trig = 1'b0;
    buildExpected();
    holdCount = 0;
    guard = 0;
    while (cpuHold === 1'b1 && guard < 200) begin
      checkOutput("capture addr", 32'(ifc.check_addr), 32'(holdCount));
      checkOutput("capture no valid", 32'(ifc.out_valid), 32'd0);
      holdCount++;
      guard++;
      trig = spamTrig ? 1'($urandom_range(1)) : 1'b0;
      step();
    end
    checkOutput("hold cycles", 32'(holdCount), 32'(NUM_ADDR));
    randomizeTable();
    sendCycles = 0;
    stallCycles = 0;
    doneSeen = 1'b0;
    guard = 0;
    while (!doneSeen && guard < 500) begin
      if (done === 1'b1) begin
        doneSeen = 1'b1;
      end else begin
        checkOutput("send busy", 32'(busy), 32'd1);
        checkOutput("send hold low", 32'(cpuHold), 32'd0);
        case (readyMode)
          0:       rdy = 1'b1;
          1:       rdy = (sendCycles % 3 == 0);
          default: rdy = 1'($urandom_range(1));
        endcase
        if (ifc.out_valid === 1'b1) begin
          checkOutput("word pending", 32'(expAddr.size() > 0), 32'd1);
          if (expAddr.size() > 0) begin
            checkOutput("out_addr", 32'(ifc.out_addr), 32'(expAddr[0]));
            checkOutput("out_data", ifc.out_data, expData[0]);
            if (rdy) begin
              void'(expAddr.pop_front());
              void'(expData.pop_front());
            end else begin
              stallCycles++;
            end
          end
        end
        ifc.out_ready = rdy;
        trig = spamTrig ? 1'($urandom_range(1)) : 1'b0;
        sendCycles++;
        guard++;
        step();
      end
    end
    checkOutput("done seen", 32'(doneSeen), 32'd1);
    checkOutput("words left at done", 32'(expAddr.size()), 32'd0);
    checkOutput("idle at done", 32'(busy), 32'd0);
`ifndef CHECK_SNAPSHOT_SKIP_ZERO_EN
    checkOutput("send cycles", 32'(sendCycles), 32'(NUM_ADDR + stallCycles));
`endif
    ifc.out_ready = 1'b0;
    trig = trigAtDone;
    step();
    trig = 1'b0;
    checkOutput("done single pulse", 32'(done), 32'd0);
    if (trigAtDone) begin
      checkOutput("restart hold", 32'(cpuHold), 32'd1);
    end else begin
      step();
      checkOutput("stays idle", 32'({busy, cpuHold}), 32'd0);
    end
  endtask

  initial begin
    testsRun = 0;
    failCount = 0;
    rst = 1'b1;
    trig = 1'b0;
    trig1 = 1'b0;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) muxTable[i] = 32'h100 + 32'(i);
    step();
    step();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset hold", 32'(cpuHold), 32'd0);
    checkOutput("reset outputs", 32'({ifc.out_valid, ifc.out_addr, ifc.check_addr, done}), 32'd0);
    checkOutput("reset out_data", ifc.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("[TB] fixed mux pattern, always ready");
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] random data, ready 1,0,0 pattern");
    randomizeTable();
    applyStimulus(1, 1'b0, 1'b0, 1'b0);

    $display("[TB] trig spam, restart on done");
    randomizeTable();
    applyStimulus(2, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during capture");
    randomizeTable();
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (10) step();
    checkOutput("hold before reset", 32'(cpuHold), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async hold release", 32'(cpuHold), 32'd0);
    checkOutput("async busy release", 32'(busy), 32'd0);
    checkOutput("async check_addr", 32'(ifc.check_addr), 32'd0);
    for (int i = 0; i < NUM_ADDR; i++) begin
      checkOutput("buffer cleared", dut.u_buf.mem_q[i], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checkOutput("no done after abort", 32'({done, busy}), 32'd0);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-entry instance");
    trig1 = 1'b1;
    step();
    trig1 = 1'b0;
    checkOutput("n1 hold", 32'(cpuHold1), 32'd1);
    step();
    checkOutput("n1 hold released", 32'(cpuHold1), 32'd0);
    checkOutput("n1 valid", 32'(ifc1.out_valid), 32'd1);
    checkOutput("n1 addr", 32'(ifc1.out_addr), 32'd0);
    checkOutput("n1 data", ifc1.out_data, 32'hDEADBEEF);
    step();
    checkOutput("n1 done", 32'({done1, busy1}), 32'b10);
    step();
    checkOutput("n1 done pulse end", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
